// File: rtl/serial_alu.sv
// Nibble-serial add/sub/multiply unit: collects two DATA_W operands in IN_W beats,
// executes one operation, and streams the DATA_W result back in OUT_W beats.
module serial_alu #(
    parameter int DATA_W = 16,
    parameter int IN_W   = 4,
    parameter int OUT_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic [IN_W-1:0]  in_b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             out_flag,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int NI  = DATA_W / IN_W;
    localparam int NO  = DATA_W / OUT_W;
    localparam int ICW = (NI > 1) ? $clog2(NI) : 1;
    localparam int OCW = (NO > 1) ? $clog2(NO) : 1;
    localparam logic [ICW-1:0] IN_LAST  = ICW'(NI - 1);
    localparam logic [OCW-1:0] OUT_LAST = OCW'(NO - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_EXEC = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t              state;
    logic [ICW-1:0]      in_cnt;
    logic [OCW-1:0]      out_cnt;
    logic [OCW-1:0]      out_nxt;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic [1:0]          op_reg;
    logic [DATA_W-1:0]   res_reg;
    logic [DATA_W-1:0]   res_next;
    logic                flag_next;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] prod;

    // Handshake: a beat moves on a rising edge where valid && ready are both high;
    // a producer holding valid keeps its payload stable until that edge. Both
    // in_ready and out_valid are registered, so neither depends on the partner's signal.

    always_comb begin
        sum       = {1'b0, a_reg} + {1'b0, b_reg};
        diff      = {1'b0, a_reg} - {1'b0, b_reg};
        prod      = {{DATA_W{1'b0}}, a_reg} * {{DATA_W{1'b0}}, b_reg};
        res_next  = '0;
        flag_next = 1'b0;
        case (op_reg)
            2'b00: begin
                res_next  = sum[DATA_W-1:0];
                flag_next = sum[DATA_W];
            end
            2'b01: begin
                // The extra top bit of the widened difference is the unsigned borrow.
                res_next  = diff[DATA_W-1:0];
                flag_next = diff[DATA_W];
            end
            2'b10: begin
                res_next  = prod[DATA_W-1:0];
                flag_next = |prod[2*DATA_W-1:DATA_W];
            end
            default: begin
                res_next  = prod[2*DATA_W-1:DATA_W];
                flag_next = 1'b0;
            end
        endcase
    end

    assign out_nxt   = out_cnt + OCW'(1);
    assign busy      = !((state == ST_LOAD) && (in_cnt == '0));
    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_LOAD;
            in_cnt    <= '0;
            out_cnt   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            res_reg   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_flag  <= 1'b0;
        end else if (clear) begin
            // Abort wins over any beat arriving on the same edge.
            state     <= ST_LOAD;
            in_cnt    <= '0;
            out_cnt   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            res_reg   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_flag  <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        a_reg[in_cnt*IN_W +: IN_W] <= in_a;
                        b_reg[in_cnt*IN_W +: IN_W] <= in_b;
                        if (in_cnt == '0) begin
                            op_reg <= op;
                        end
                        if (in_cnt == IN_LAST) begin
                            in_cnt   <= '0;
                            in_ready <= 1'b0;
                            state    <= ST_EXEC;
                        end else begin
                            in_cnt <= in_cnt + ICW'(1);
                        end
                    end
                end
                ST_EXEC: begin
                    res_reg   <= res_next;
                    out_flag  <= flag_next;
                    out_data  <= res_next[OUT_W-1:0];
                    out_last  <= (NO == 1);
                    out_cnt   <= '0;
                    out_valid <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= ST_LOAD;
                            out_cnt   <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            out_flag  <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            out_cnt  <= out_nxt;
                            out_data <= res_reg[out_nxt*OUT_W +: OUT_W];
                            out_last <= (out_nxt == OUT_LAST);
                        end
                    end
                end
                default: begin
                    state    <= ST_LOAD;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
